// File: rtl/char_ram_arbiter.sv
// Shares one character RAM port between the text-mode video fetcher and a Wishbone slave.
// Video always wins the port; Wishbone waits for free cycles and flags starvation.
module char_ram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              wb_starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } wb_state_t;

    // Who issued the read whose data appears on ram_rdata this cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_WB
    } owner_t;

    wb_state_t        state;
    owner_t           owner;
    logic             wb_req;
    logic             wb_grant;
    logic [CNT_W-1:0] wait_cnt;

    assign wb_req   = wb_cyc & wb_stb;
    assign wb_grant = !rst && (state == IDLE) && wb_req && !vid_req;

    // The port is steered combinationally so video gets the RAM in the cycle it asks.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!rst) begin
            if (vid_req) begin
                ram_en   = 1'b1;
                ram_addr = vid_addr;
            end else if (wb_grant) begin
                ram_en    = 1'b1;
                ram_we    = wb_we;
                ram_addr  = wb_adr;
                ram_wdata = wb_dat_i;
            end
        end
    end

    assign wb_starved = (wait_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            wb_ack    <= 1'b0;
            wb_dat_o  <= '0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            wait_cnt  <= '0;
        end else begin
            if (vid_req)
                owner <= OWN_VID;
            else if (wb_grant && !wb_we)
                owner <= OWN_WB;
            else
                owner <= OWN_NONE;

            vid_valid <= (owner == OWN_VID);
            if (owner == OWN_VID)
                vid_data <= ram_rdata;
            if (owner == OWN_WB)
                wb_dat_o <= ram_rdata;

            wb_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_grant) begin
                        state  <= wb_we ? ACK : RD_WAIT;
                        wb_ack <= wb_we;
                    end
                end
                RD_WAIT: begin
                    state  <= ACK;
                    wb_ack <= 1'b1;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase

            // Only an IDLE request blocked by video counts as waiting.
            if ((state == IDLE) && wb_req && vid_req) begin
                if (wait_cnt != CNT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Self-checking bench for char_ram_arbiter: cycle-indexed schedule model of the
// arbitration rules, a RAM model behind the port, directed cases and random traffic.
module tb_char_ram_arbiter;

    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              wb_cyc = 1'b0;
    logic              wb_stb = 1'b0;
    logic              wb_we = 1'b0;
    logic [ADDR_W-1:0] wb_adr = '0;
    logic [DATA_W-1:0] wb_dat_i = '0;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic              wb_starved;

    char_ram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack    (wb_ack),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wb_starved(wb_starved)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 37 + 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    // ---------------- RAM behind the port ----------------
    logic [DATA_W-1:0] ram_w [int];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                ram_w[int'(ram_addr)] = ram_wdata;
            else
                ram_rdata <= ram_w.exists(int'(ram_addr)) ? ram_w[int'(ram_addr)] : init_val(ram_addr);
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_w [int];
    logic [DATA_W-1:0] vid_sched [int];
    logic [DATA_W-1:0] rd_sched [int];
    bit                ack_sched [int];
    logic [DATA_W-1:0] vid_hold = '0;
    logic [DATA_W-1:0] wb_hold = '0;
    int                wcnt = 0;
    int                wb_free = 0;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_w.exists(int'(a)) ? ref_w[int'(a)] : init_val(a);
    endfunction

    always @(negedge clk) begin
        logic              req, e_en, e_we, e_vv, e_ack, e_st, e_wb;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        if (rst) begin
            chk("rst_ram_en", 32'(ram_en), 32'(0));
            chk("rst_wb_ack", 32'(wb_ack), 32'(0));
            chk("rst_vid_valid", 32'(vid_valid), 32'(0));
            chk("rst_wb_starved", 32'(wb_starved), 32'(0));
            chk("rst_vid_data", 32'(vid_data), 32'(0));
            chk("rst_wb_dat_o", 32'(wb_dat_o), 32'(0));
            vid_sched.delete();
            rd_sched.delete();
            ack_sched.delete();
            vid_hold = '0;
            wb_hold  = '0;
            wcnt     = 0;
            wb_free  = t + 1;
        end else begin
            req    = wb_cyc & wb_stb;
            e_st   = (wcnt == STARVE_LIMIT);
            e_en   = 1'b0;
            e_we   = 1'b0;
            e_wb   = 1'b0;
            e_addr = '0;
            e_wd   = '0;
            if (vid_req) begin
                e_en   = 1'b1;
                e_addr = vid_addr;
                vid_sched[t + 2] = ref_rd(vid_addr);
            end else if (req && t >= wb_free) begin
                e_en   = 1'b1;
                e_wb   = 1'b1;
                e_we   = wb_we;
                e_addr = wb_adr;
                e_wd   = wb_dat_i;
                if (wb_we) begin
                    ref_w[int'(wb_adr)] = wb_dat_i;
                    ack_sched[t + 1] = 1'b1;
                    wb_free = t + 2;
                end else begin
                    ack_sched[t + 2] = 1'b1;
                    rd_sched[t + 2]  = ref_rd(wb_adr);
                    wb_free = t + 3;
                end
            end
            if (req && vid_req && t >= wb_free)
                wcnt = (wcnt < STARVE_LIMIT) ? wcnt + 1 : STARVE_LIMIT;
            else
                wcnt = 0;
            e_vv = vid_sched.exists(t);
            if (e_vv)
                vid_hold = vid_sched[t];
            e_ack = ack_sched.exists(t);
            if (rd_sched.exists(t))
                wb_hold = rd_sched[t];

            chk("ram_en", 32'(ram_en), 32'(e_en));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            if (e_en)
                chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_wb)
                chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
            chk("vid_valid", 32'(vid_valid), 32'(e_vv));
            chk("vid_data", 32'(vid_data), 32'(vid_hold));
            chk("wb_ack", 32'(wb_ack), 32'(e_ack));
            chk("wb_dat_o", 32'(wb_dat_o), 32'(wb_hold));
            chk("wb_starved", 32'(wb_starved), 32'(e_st));
        end
        t++;
    end

    // ---------------- driver ----------------
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] va, input logic c, input logic s,
                         input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #1;
        vid_req  = v;
        vid_addr = va;
        wb_cyc   = c;
        wb_stb   = s;
        wb_we    = we;
        wb_adr   = a;
        wb_dat_i = d;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    logic              m_active;
    logic              m_we;
    logic [ADDR_W-1:0] m_adr;
    logic [DATA_W-1:0] m_dat;
    int                wait_n;
    int                p;

    initial begin
        @(negedge clk);
        chk("lit_reset_ram_en", 32'(ram_en), 32'(0));
        chk("lit_reset_wb_dat_o", 32'(wb_dat_o), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Write 0x41 to 0x123, then read it back.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 11'h123, 8'h41);
        @(negedge clk);
        chk("lit_wr_ram_we", 32'(ram_we), 32'(1));
        chk("lit_wr_ram_addr", 32'(ram_addr), 32'h123);
        chk("lit_wr_ram_wdata", 32'(ram_wdata), 32'h41);
        chk("lit_wr_ack_at_g", 32'(wb_ack), 32'(0));
        idle();
        @(negedge clk);
        chk("lit_wr_ack_g1", 32'(wb_ack), 32'(1));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        @(negedge clk);
        chk("lit_rd_ram_we", 32'(ram_we), 32'(0));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        @(negedge clk);
        chk("lit_rd_ack_g1", 32'(wb_ack), 32'(0));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        @(negedge clk);
        chk("lit_rd_ack_g2", 32'(wb_ack), 32'(1));
        chk("lit_rd_data", 32'(wb_dat_o), 32'h41);
        idle();
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 11'h124, 8'hA5);
        idle();
        idle();

        // Video holds the port for 100 cycles while a read waits.
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, ADDR_W'(i), 1'b1, 1'b1, 1'b0, 11'h200, '0);
            @(negedge clk);
            if (i == 63) chk("lit_starve_63", 32'(wb_starved), 32'(0));
            if (i == 64) chk("lit_starve_64", 32'(wb_starved), 32'(1));
            if (i == 99) chk("lit_starve_vid_addr", 32'(ram_addr), 32'd99);
        end
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h200, '0);
        @(negedge clk);
        chk("lit_starve_grant_addr", 32'(ram_addr), 32'h200);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h200, '0);
        @(negedge clk);
        chk("lit_starve_cleared", 32'(wb_starved), 32'(0));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h200, '0);
        @(negedge clk);
        chk("lit_starve_ack", 32'(wb_ack), 32'(1));
        idle();

        // Alternating video with back-to-back writes.
        for (int i = 0; i < 8; i++) begin
            cycle((i % 2) == 0, ADDR_W'(16 + i), 1'b1, 1'b1, 1'b1, ADDR_W'(768 + i), DATA_W'(i + 1));
            @(negedge clk);
            chk("lit_alt_ram_we", 32'(ram_we), 32'((i % 2) == 1));
            chk("lit_alt_vid_valid", 32'(vid_valid), 32'(i >= 2 && (i % 2) == 0));
        end
        idle();
        idle();

        // Wishbone read at G, video read at G+1: data lands in separate registers.
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        cycle(1'b1, 11'h124, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        @(negedge clk);
        chk("lit_mix_wb_ack", 32'(wb_ack), 32'(1));
        chk("lit_mix_wb_dat", 32'(wb_dat_o), 32'h41);
        chk("lit_mix_vv_early", 32'(vid_valid), 32'(0));
        idle();
        @(negedge clk);
        chk("lit_mix_vid_valid", 32'(vid_valid), 32'(1));
        chk("lit_mix_vid_data", 32'(vid_data), 32'hA5);
        chk("lit_mix_wb_hold", 32'(wb_dat_o), 32'h41);

        // Reset in RD_WAIT with a video read also in flight.
        cycle(1'b1, 11'h124, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h123, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_rst_ack", 32'(wb_ack), 32'(0));
        chk("lit_rst_vid_valid", 32'(vid_valid), 32'(0));
        chk("lit_rst_wb_dat_o", 32'(wb_dat_o), 32'(0));
        chk("lit_rst_vid_data", 32'(vid_data), 32'(0));
        idle();
        @(negedge clk);
        chk("lit_rst_ack_late", 32'(wb_ack), 32'(0));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 11'h125, 8'h3C);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_post_rst_grant", 32'(ram_we), 32'(1));
        idle();
        @(negedge clk);
        chk("lit_post_rst_ack", 32'(wb_ack), 32'(1));
        idle();

        // Write stuck behind video, then dropped.
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, ADDR_W'(i), 1'b1, 1'b1, 1'b1, 11'h126, 8'h77);
            @(negedge clk);
            if (i == 69) chk("lit_drop_starved", 32'(wb_starved), 32'(1));
        end
        cycle(1'b1, '0, 1'b0, 1'b0, 1'b1, 11'h126, 8'h77);
        idle();
        @(negedge clk);
        chk("lit_drop_cnt_cleared", 32'(wb_starved), 32'(0));
        chk("lit_drop_no_access", 32'(ram_en), 32'(0));
        idle();
        @(negedge clk);
        chk("lit_drop_no_ack", 32'(wb_ack), 32'(0));
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 11'h126, '0);
        idle();
        idle();
        @(negedge clk);
        chk("lit_drop_not_written", 32'(wb_dat_o), 32'(init_val(11'h126)));

        // Random traffic in phases of light, medium and heavy video load.
        m_active = 1'b0;
        wait_n   = 0;
        for (int i = 0; i < 3000; i++) begin
            p = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 50 : 95);
            if (!m_active && $urandom_range(3) == 0) begin
                m_active = 1'b1;
                m_we     = 1'($urandom_range(1));
                m_adr    = ADDR_W'($urandom_range(31));
                m_dat    = DATA_W'($urandom);
                wait_n   = 0;
            end else if (m_active && $urandom_range(59) == 0) begin
                m_active = 1'b0;
            end
            cycle(int'($urandom_range(99)) < p, ADDR_W'($urandom_range(31)),
                  m_active | ($urandom_range(7) == 0), m_active, m_we, m_adr, m_dat);
            @(negedge clk);
            if (wb_ack) begin
                m_active = 1'b0;
            end else if (m_active) begin
                wait_n++;
                if (wait_n > 400) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_txn_timeout cycle=%0d actual=no_ack required=ack_within_400", t);
                    m_active = 1'b0;
                end
            end
        end
        repeat (4) idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
